mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequencer for the MAR/MDR memory path. Arbitrates between the instruction-fetch
//  and data (LDR/STR/LDI/STI) requesters. Drives LD_MAR, the MAR address-source
//  select, MIO_EN/LD_MDR on the MDR input mux, and the active-low SRAM strobes,
//  with parameterised wait states. Sits between the CPU control FSM and the MDR/SRAM.
// PARAMETERS
//  READ_WAIT   2  cycles SRAM OE/CE held before the MDR captures; legal 1..15
//  WRITE_WAIT  2  cycles WE held low; legal 1..15
// PORTS
//  Clk         in   1  system clock; all state changes on rising edge
//  Reset       in   1  synchronous, active-low reset
//  Req_Fetch   in   1  fetch request (always a read)
//  Req_Data    in   1  data request
//  RW_Data     in   1  data direction: 1=write, 0=read; sampled at grant
//  Done_Fetch  out  1  one-cycle completion pulse to fetch requester
//  Done_Data   out  1  one-cycle completion pulse to data requester
//  Busy        out  1  high in every state except IDLE
//  Addr_Sel    out  1  MAR source: 0=PC (fetch), 1=ALU/addr adder (data)
//  LD_MAR      out  1  MAR load enable
//  LD_MDR      out  1  MDR load enable
//  MIO_EN      out  1  MDR mux select: 1=memory data, 0=bus
//  Mem_CE      out  1  SRAM chip enable, active low
//  Mem_OE      out  1  SRAM output enable, active low
//  Mem_WE      out  1  SRAM write enable, active low
// BEHAVIOUR
//  Reset (Reset==0 at edge): state=IDLE, counter=0, grant=none. Outputs:
//   Done_*=0, Busy=0, Addr_Sel=0, LD_MAR=0, LD_MDR=0, MIO_EN=0,
//   Mem_CE=Mem_OE=Mem_WE=1. Reset mid-access aborts the access immediately
//   (WE released high the cycle after the reset edge); no Done is issued.
//  Outputs are Moore (decoded from registered state and grant).
//  FSM states: IDLE, ADDR, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
//  - IDLE: if Req_Data, grant DATA and latch RW_Data; else if Req_Fetch, grant
//    FETCH (RW=read); else stay. Both high: DATA wins, fetch is served next.
//  - ADDR (1 cycle): LD_MAR=1, Addr_Sel=grant. Next RD_WAIT or WR_SETUP;
//    counter is loaded with the respective WAIT-1.
//  - RD_WAIT (READ_WAIT cycles): Mem_CE=0, Mem_OE=0, MIO_EN=1. LD_MDR=1 only
//    in the last cycle (counter==0). Next DONE.
//  - WR_SETUP (1 cycle): Mem_CE=0, Mem_OE=1, Mem_WE=1, MIO_EN=0.
//  - WR_PULSE (WRITE_WAIT cycles): Mem_CE=0, Mem_WE=0. Next WR_HOLD.
//  - WR_HOLD (1 cycle): Mem_CE=0, Mem_WE=1 (data hold). Next DONE.
//  - DONE (1 cycle): Done_<grant>=1, strobes inactive. Next IDLE. There is no
//    back-to-back grant from DONE; a re-request is seen in IDLE.
//  Latency: with the request sampled in IDLE at cycle N, a read gives Done in
//   cycle N+2+READ_WAIT; a write gives Done in cycle N+4+WRITE_WAIT.
//  The counter is 4 bits and counts down. It saturates at 0 and never wraps.
//  Requests are level. A requester holds Req until its Done. A Req dropped
//   after grant does not cancel the access; it completes and Done still pulses.
//  MIO_EN=0 and LD_MDR=0 in all write states, so the MDR contents written by the
//   bus path before the request are preserved.
//  Mem_OE and Mem_WE are never both low. Mem_WE is low only in WR_PULSE.
// STRUCTURE
//  Package lc3_mem_pkg: state enum (mem_state_t), grant enum (GNT_NONE/FETCH/
//   DATA), WAIT_W=4 constant.
//  Sub-module mem_wait_counter: loadable 4-bit down-counter with zero flag.
//  The top holds the FSM, grant/RW registers and output decode.
// TESTING
//  1 Reset low 2 cycles mid-WR_PULSE -> next cycle Mem_WE=1, Busy=0, no Done.
//  2 Req_Fetch at N, defaults -> LD_MAR at N+1; OE low N+2..N+3; LD_MDR at N+3;
//    Done_Fetch at N+4 only.
//  3 Req_Data,RW_Data=1 at N -> WE low N+3..N+4; Done_Data N+6; LD_MDR never 1.
//  4 Req_Fetch and Req_Data both high at N -> data served first (Addr_Sel=1).
//    Fetch granted in the IDLE after DONE; Addr_Sel=0 at its ADDR cycle.
//  5 READ_WAIT=1, WRITE_WAIT=15 -> read Done at N+3, write Done at N+19.
//  6 Req_Data dropped the cycle after grant -> access completes, Done_Data pulses.
//  Assertions throughout: !(~Mem_OE & ~Mem_WE); Done one-hot-or-zero;
//   LD_MDR implies MIO_EN.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// lc3_mem_pkg: shared state/grant types and counter width for the MAR/MDR memory sequencer.
package lc3_mem_pkg;
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } mem_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DATA} grant_t;
  // A wait of N cycles is counted N-1 down to 0 inclusive.
  function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
    return WAIT_W'(cycles - 1);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: requester handshake plus MAR/MDR/SRAM control strobes.
interface mem_access_ctrl_if;
  logic req_fetch;
  logic req_data;
  logic rw_data;
  logic done_fetch;
  logic done_data;
  logic busy;
  logic addr_sel;
  logic ld_mar;
  logic ld_mdr;
  logic mio_en;
  logic mem_ce;
  logic mem_oe;
  logic mem_we;
  modport master (
    output req_fetch, req_data, rw_data,
    input  done_fetch, done_data, busy, addr_sel, ld_mar, ld_mdr, mio_en, mem_ce, mem_oe, mem_we
  );
  modport slave (
    input  req_fetch, req_data, rw_data,
    output done_fetch, done_data, busy, addr_sel, ld_mar, ld_mdr, mio_en, mem_ce, mem_oe, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// mem_wait_counter: loadable down-counter that saturates at zero, with zero flag.
module mem_wait_counter
  import lc3_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch/data requests and sequences MAR load, MDR capture
// and the active-low SRAM strobes with parameterised read/write wait states.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_access_ctrl_if.slave  bus
);
  mem_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              rw_q, rw_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [WAIT_W-1:0] cnt_val;

  mem_wait_counter u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= GNT_NONE;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rw_d     = rw_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Data has priority; a held fetch request is picked up in the following IDLE.
        if (bus.req_data) begin
          grant_d = GNT_DATA;
          rw_d    = bus.rw_data;
          state_d = S_ADDR;
        end else if (bus.req_fetch) begin
          grant_d = GNT_FETCH;
          rw_d    = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_load = 1'b1;
        cnt_val  = rw_q ? wait_load(WRITE_WAIT) : wait_load(READ_WAIT);
        state_d  = rw_q ? S_WR_SETUP : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_dec = 1'b1;
        state_d = cnt_zero ? S_DONE : S_RD_WAIT;
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        cnt_dec = 1'b1;
        state_d = cnt_zero ? S_WR_HOLD : S_WR_PULSE;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE: begin
        grant_d = GNT_NONE;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ld_mar     = (state_q == S_ADDR);
  assign bus.addr_sel   = (state_q == S_ADDR) && (grant_q == GNT_DATA);
  assign bus.mio_en     = (state_q == S_RD_WAIT);
  assign bus.ld_mdr     = (state_q == S_RD_WAIT) && cnt_zero;
  assign bus.mem_ce     = !(state_q inside {S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
  assign bus.mem_oe     = (state_q != S_RD_WAIT);
  assign bus.mem_we     = (state_q != S_WR_PULSE);
  assign bus.done_fetch = (state_q == S_DONE) && (grant_q == GNT_FETCH);
  assign bus.done_data  = (state_q == S_DONE) && (grant_q == GNT_DATA);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized requests on two parameterisations, scoreboarded Done timing
// plus per-cycle strobe expectations derived from phase offsets of each access.
module tb_mem_access_ctrl;
  typedef struct packed {
    logic done_f, done_d, busy, addr_sel, ld_mar, ld_mdr, mio_en, ce, oe, we;
  } ov_t;
  typedef struct { bit data; int cyc; } sb_t;
  localparam int DEPTH = 8192;
  localparam ov_t IDLE_V = 10'b0000000111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_f [2];
  logic req_d [2];
  logic rw_dt [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   free_at [2];
  int   rwait [2] = '{2, 1};
  int   wwait [2] = '{2, 15};
  ov_t  ev [2][DEPTH];
  ov_t  act [2];
  sb_t  q0 [$];
  sb_t  q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if bus0 ();
  mem_access_ctrl_if bus1 ();

  mem_access_ctrl #(.READ_WAIT(2), .WRITE_WAIT(2)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  mem_access_ctrl #(.READ_WAIT(1), .WRITE_WAIT(15)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  assign bus0.req_fetch = req_f[0];
  assign bus0.req_data  = req_d[0];
  assign bus0.rw_data   = rw_dt[0];
  assign bus1.req_fetch = req_f[1];
  assign bus1.req_data  = req_d[1];
  assign bus1.rw_data   = rw_dt[1];
  assign act[0] = {bus0.done_fetch, bus0.done_data, bus0.busy, bus0.addr_sel, bus0.ld_mar,
                   bus0.ld_mdr, bus0.mio_en, bus0.mem_ce, bus0.mem_oe, bus0.mem_we};
  assign act[1] = {bus1.done_fetch, bus1.done_data, bus1.busy, bus1.addr_sel, bus1.ld_mar,
                   bus1.ld_mdr, bus1.mio_en, bus1.mem_ce, bus1.mem_oe, bus1.mem_we};

  function automatic int lat(input int d, input bit rw);
    return rw ? 4 + wwait[d] : 2 + rwait[d];
  endfunction

  function automatic void put(input int d, input int c, input ov_t v);
    if (c >= 0 && c < DEPTH) ev[d][c] = v;
  endfunction

  // Expected outputs for one access granted from IDLE in cycle n.
  function automatic void fill(input int d, input bit data, input bit rw, input int n);
    ov_t v;
    v = IDLE_V; v.busy = 1; v.ld_mar = 1; v.addr_sel = data;
    put(d, n + 1, v);
    if (!rw) begin
      for (int k = 0; k < rwait[d]; k++) begin
        v = IDLE_V; v.busy = 1; v.ce = 0; v.oe = 0; v.mio_en = 1; v.ld_mdr = (k == rwait[d] - 1);
        put(d, n + 2 + k, v);
      end
    end else begin
      v = IDLE_V; v.busy = 1; v.ce = 0;
      put(d, n + 2, v);
      put(d, n + 3 + wwait[d], v);
      v.we = 0;
      for (int k = 0; k < wwait[d]; k++) put(d, n + 3 + k, v);
    end
    v = IDLE_V; v.busy = 1; v.done_f = !data; v.done_d = data;
    put(d, n + lat(d, rw), v);
  endfunction

  function automatic void push(input int d, input bit data, input int c);
    sb_t s;
    s.data = data; s.cyc = c;
    if (d == 0) q0.push_back(s);
    else q1.push_back(s);
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic txn(input int d, input bit wf, input bit wd, input bit rw, input bit early);
    int n, nd, last, t0;
    t0 = cyc;
    n = (cyc > free_at[d]) ? cyc : free_at[d];
    nd = n;
    last = n;
    req_f[d] = wf; req_d[d] = wd; rw_dt[d] = rw;
    if (wd) begin
      fill(d, 1, rw, n);
      last = n + lat(d, rw);
      push(d, 1, last);
      n = last + 1;
    end
    if (wf) begin
      fill(d, 0, 0, n);
      last = n + lat(d, 0);
      push(d, 0, last);
    end
    free_at[d] = last + 1;
    while (cyc < last + 1 && cyc < t0 + 200) begin
      step();
      if (cyc > nd) rw_dt[d] = 1'($urandom);
      if (act[d].done_f) req_f[d] = 0;
      if (act[d].done_d || (early && cyc == nd + 1)) req_d[d] = 0;
    end
    req_f[d] = 0; req_d[d] = 0;
  endtask

  // Write on dut0 aborted by a two-cycle reset during its first WE-low cycle.
  task automatic rst_test();
    int n, t0;
    t0 = cyc;
    n = (cyc > free_at[0]) ? cyc : free_at[0];
    req_d[0] = 1; rw_dt[0] = 1;
    fill(0, 1, 1, n);
    push(0, 1, n + lat(0, 1));
    while (cyc < n + 3 && cyc < t0 + 50) step();
    rst_n = 0; req_d[0] = 0;
    for (int i = n + 4; i <= n + lat(0, 1); i++) put(0, i, IDLE_V);
    if (q0.size() > 0) void'(q0.pop_back());
    idle(2);
    rst_n = 1;
    free_at[0] = cyc; free_at[1] = cyc;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        ov_t a, e, m;
        sb_t s;
        bit empty;
        a = act[d];
        e = (cyc < DEPTH) ? ev[d][cyc] : IDLE_V;
        m = '1;
        if (!e.ld_mar) m.addr_sel = 0;
        checks++;
        if (((a ^ e) & m) != '0) begin
          errors++;
          $display("FAIL outputs dut%0d cyc %0d got %b exp %b (done_f done_d busy asel ldmar ldmdr mio ce oe we)", d, cyc, a, e);
        end
        checks++;
        if (!a.oe && !a.we) begin
          errors++;
          $display("FAIL oe_we_overlap dut%0d cyc %0d got oe=%b we=%b exp not both 0", d, cyc, a.oe, a.we);
        end
        checks++;
        if (a.done_f && a.done_d) begin
          errors++;
          $display("FAIL done_onehot dut%0d cyc %0d got %b%b exp at most one", d, cyc, a.done_f, a.done_d);
        end
        checks++;
        if (a.ld_mdr && !a.mio_en) begin
          errors++;
          $display("FAIL ldmdr_mio dut%0d cyc %0d got ld_mdr=1 mio_en=0 exp mio_en=1", d, cyc);
        end
        if (a.done_f || a.done_d) begin
          checks++;
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            errors++;
            $display("FAIL done_unexpected dut%0d cyc %0d got done %b%b exp none", d, cyc, a.done_f, a.done_d);
          end else begin
            if (d == 0) s = q0.pop_front();
            else s = q1.pop_front();
            if (s.data != a.done_d || s.cyc != cyc) begin
              errors++;
              $display("FAIL done_sb dut%0d got data=%0d cyc=%0d exp data=%0d cyc=%0d", d, a.done_d, cyc, s.data, s.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int d, k;
    for (int j = 0; j < 2; j++) begin
      req_f[j] = 0; req_d[j] = 0; rw_dt[j] = 0;
      for (int i = 0; i < DEPTH; i++) ev[j][i] = IDLE_V;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    free_at[0] = cyc; free_at[1] = cyc;
    mon_en = 1;
    idle(2);
    txn(0, 1, 0, 0, 0); idle(1);
    txn(0, 0, 1, 1, 0); idle(1);
    txn(0, 1, 1, 0, 0);
    txn(0, 1, 1, 1, 0); idle(2);
    txn(1, 0, 1, 0, 0);
    txn(1, 0, 1, 1, 0); idle(1);
    txn(0, 0, 1, 0, 1);
    txn(0, 0, 1, 1, 1); idle(1);
    rst_test(); idle(2);
    repeat (120) begin
      d = $urandom_range(0, 1);
      k = $urandom_range(0, 3);
      txn(d, k == 0 || k == 2, k != 0, 1'($urandom), k == 3);
      idle($urandom_range(0, 3));
    end
    idle(3);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL sb_drain dut0 got %0d pending exp 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain dut1 got %0d pending exp 0", q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
